// File: rtl/dmem_arbiter.sv
// Shares the single-port 32-word data RAM between the CPU MEM stage and a burst DMA port.
// CPU has priority with zero added latency; either side waits at most STARVE_LIMIT cycles in a row.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 8,
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_beat,
  output logic [LEN_W-1:0]  dma_idx,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              ram_we,
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [29:0]      base_q, base_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic [SW-1:0]    dma_wait_q, dma_wait_d;
  logic             cpu_gnt, beat;
  logic [4:0]       word;
  logic [LEN_W-1:0] len_in;
  logic             unused_addr_lsbs;

  // Burst addresses are word-aligned; the byte offset bits carry no information.
  assign unused_addr_lsbs = ^dma_addr[1:0];

  assign len_in = (dma_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : dma_len;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    dir_d      = dir_q;
    len_d      = len_q;
    idx_d      = idx_q;
    streak_d   = streak_q;
    dma_wait_d = dma_wait_q;
    cpu_gnt    = 1'b0;
    beat       = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_gnt  = cpu_req;
        streak_d = '0;
        if (dma_req && (!cpu_req || dma_wait_q == SW'(STARVE_LIMIT))) begin
          base_d     = dma_addr[31:2];
          dir_d      = dma_we;
          len_d      = len_in;
          idx_d      = '0;
          dma_wait_d = '0;
          state_d    = (len_in == '0) ? DONE : BURST;
        end else if (!dma_req) begin
          dma_wait_d = '0;
        end else begin
          dma_wait_d = dma_wait_q + SW'(1);
        end
      end
      BURST: begin
        if (cpu_req && streak_q == SW'(STARVE_LIMIT)) begin
          cpu_gnt  = 1'b1;
          streak_d = '0;
        end else begin
          beat     = 1'b1;
          idx_d    = idx_q + LEN_W'(1);
          streak_d = cpu_req ? streak_q + SW'(1) : '0;
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cpu_gnt  = cpu_req;
        streak_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Nothing may reach the RAM while reset is held, even combinationally.
    if (!clrn) begin
      cpu_gnt = 1'b0;
      beat    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      base_q     <= '0;
      dir_q      <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      streak_q   <= '0;
      dma_wait_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      dir_q      <= dir_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      streak_q   <= streak_d;
      dma_wait_q <= dma_wait_d;
    end
  end

  // Word index wraps inside the 128-byte window.
  assign word = base_q[4:0] + 5'(idx_q);

  always_comb begin
    ram_addr  = beat ? {base_q[29:5], word, 2'b00} : cpu_addr;
    ram_wdata = beat ? dma_wdata : cpu_wdata;
    ram_we    = cpu_gnt ? cpu_we : (beat & dir_q);
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = ram_rdata;
  assign dma_rdata = ram_rdata;
  assign dma_beat  = beat;
  assign dma_idx   = idx_q;
  assign dma_done  = (state_q == DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences, and random traffic vs a reference model.
module tb_dmem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_beat, dma_done;
  logic [3:0]  dma_idx;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  dmem_arbiter #(.DATA_W(32), .MAX_BURST(8), .LEN_W(4), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_beat(dma_beat), .dma_idx(dma_idx), .dma_rdata(dma_rdata),
    .dma_done(dma_done), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Data RAM: combinational read, write at posedge.
  logic [31:0] mem [32];
  assign ram_rdata = mem[ram_addr[6:2]];
  always @(posedge clk) if (ram_we) mem[ram_addr[6:2]] <= ram_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic c_req, c_we; logic [31:0] c_addr, c_wd;
    logic d_req, d_we; logic [31:0] d_addr; logic [3:0] d_len; logic [31:0] d_wd;
    logic e_stall, e_beat, e_we, e_done; logic [3:0] e_idx; logic [31:0] e_addr; logic a_chk;
    logic [1:0] rd_sel; logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t v(input logic cr, cw, input logic [31:0] ca, cd,
                             input logic dr, dw, input logic [31:0] da, input logic [3:0] dl,
                             input logic [31:0] dd, input logic es, eb, ew, ed,
                             input logic [3:0] ei, input logic [31:0] ea, input logic ac,
                             input logic [1:0] rs, input logic [31:0] er);
    vec_t r;
    r.c_req = cr; r.c_we = cw; r.c_addr = ca; r.c_wd = cd;
    r.d_req = dr; r.d_we = dw; r.d_addr = da; r.d_len = dl; r.d_wd = dd;
    r.e_stall = es; r.e_beat = eb; r.e_we = ew; r.e_done = ed; r.e_idx = ei;
    r.e_addr = ea; r.a_chk = ac; r.rd_sel = rs; r.e_rd = er;
    return r;
  endfunction

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
  endtask

  // Reference model state
  int          m_mode;   // 0 idle, 1 bursting, 2 done pulse
  int          m_wait, m_run, m_nb;
  logic        m_dir;
  logic [31:0] m_q[$];
  logic [31:0] m_mem [32];

  vec_t tv[19];

  initial begin
    logic [31:0] pre [6];
    int k, run, maxrun;
    logic eb, es, ed;

    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + i;
    idle_inputs();
    clrn = 0;
    cpu_req = 1;
    #3;
    chk("reset_stall", {31'd0, cpu_stall}, 1);
    chk("reset_we", {31'd0, ram_we}, 0);
    chk("reset_beat", {31'd0, dma_beat}, 0);
    chk("reset_done", {31'd0, dma_done}, 0);
    cpu_req = 0;
    @(negedge clk);
    clrn = 1;
    #1 chk("reset_idx", {28'd0, dma_idx}, 0);

    // cr cw addr wdata | dr dw addr len wdata | stall beat we done idx addr achk | rd_sel rd
    tv[0]  = v(1,1,32'h50,32'hA3, 0,0,0,0,0,           0,0,1,0,0,32'h50,1, 0,0);
    tv[1]  = v(1,0,32'h50,0,      0,0,0,0,0,           0,0,0,0,0,32'h50,1, 1,32'hA3);
    tv[2]  = v(0,0,0,0,           1,0,32'h50,4,0,      0,0,0,0,0,0,0,      0,0);
    tv[3]  = v(0,0,0,0,           1,0,32'h50,4,0,      0,1,0,0,0,32'h50,1, 2,32'hA3);
    tv[4]  = v(0,0,0,0,           1,0,32'h50,4,0,      0,1,0,0,1,32'h54,1, 2,32'hC0DE0015);
    tv[5]  = v(0,0,0,0,           1,0,32'h50,4,0,      0,1,0,0,2,32'h58,1, 2,32'hC0DE0016);
    tv[6]  = v(0,0,0,0,           1,0,32'h50,4,0,      0,1,0,0,3,32'h5C,1, 2,32'hC0DE0017);
    tv[7]  = v(0,0,0,0,           0,0,0,0,0,           0,0,0,1,0,0,0,      0,0);
    tv[8]  = v(0,0,0,0,           1,1,32'h78,4,0,      0,0,0,0,0,0,0,      0,0);
    tv[9]  = v(0,0,0,0,           1,1,32'h78,4,32'hB0, 0,1,1,0,0,32'h78,1, 0,0);
    tv[10] = v(0,0,0,0,           1,1,32'h78,4,32'hB1, 0,1,1,0,1,32'h7C,1, 0,0);
    tv[11] = v(0,0,0,0,           1,1,32'h78,4,32'hB2, 0,1,1,0,2,32'h00,1, 0,0);
    tv[12] = v(0,0,0,0,           1,1,32'h78,4,32'hB3, 0,1,1,0,3,32'h04,1, 0,0);
    tv[13] = v(0,0,0,0,           0,0,0,0,0,           0,0,0,1,0,0,0,      0,0);
    tv[14] = v(1,0,32'h00,0,      0,0,0,0,0,           0,0,0,0,0,32'h00,1, 1,32'hB2);
    tv[15] = v(1,0,32'h7C,0,      0,0,0,0,0,           0,0,0,0,0,32'h7C,1, 1,32'hB1);
    tv[16] = v(0,0,0,0,           1,1,32'h20,0,0,      0,0,0,0,0,0,0,      0,0);
    tv[17] = v(0,0,0,0,           0,0,0,0,0,           0,0,0,1,0,0,0,      0,0);
    tv[18] = v(0,0,0,0,           0,0,0,0,0,           0,0,0,0,0,0,0,      0,0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      cpu_req = tv[i].c_req; cpu_we = tv[i].c_we; cpu_addr = tv[i].c_addr; cpu_wdata = tv[i].c_wd;
      dma_req = tv[i].d_req; dma_we = tv[i].d_we; dma_addr = tv[i].d_addr;
      dma_len = tv[i].d_len; dma_wdata = tv[i].d_wd;
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, cpu_stall}, {31'd0, tv[i].e_stall});
      chk($sformatf("v%0d_beat", i), {31'd0, dma_beat}, {31'd0, tv[i].e_beat});
      chk($sformatf("v%0d_we", i), {31'd0, ram_we}, {31'd0, tv[i].e_we});
      chk($sformatf("v%0d_done", i), {31'd0, dma_done}, {31'd0, tv[i].e_done});
      if (tv[i].e_beat) chk($sformatf("v%0d_idx", i), {28'd0, dma_idx}, {28'd0, tv[i].e_idx});
      if (tv[i].a_chk) chk($sformatf("v%0d_addr", i), ram_addr, tv[i].e_addr);
      if (tv[i].rd_sel == 2'd1) chk($sformatf("v%0d_cpu_rd", i), cpu_rdata, tv[i].e_rd);
      if (tv[i].rd_sel == 2'd2) chk($sformatf("v%0d_dma_rd", i), dma_rdata, tv[i].e_rd);
    end

    // CPU hammers the RAM while an 8-beat write waits, then runs.
    k = 0; run = 0; maxrun = 0;
    for (int c = 1; c <= 15; c++) begin
      eb = (c >= 6 && c <= 9) || (c >= 11 && c <= 14);
      es = eb;
      ed = (c == 15);
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
      dma_req = (c < 15); dma_we = 1; dma_addr = 32'h40; dma_len = 8;
      dma_wdata = 32'h5000 + k;
      #1;
      chk($sformatf("s3_c%0d_beat", c), {31'd0, dma_beat}, {31'd0, eb});
      chk($sformatf("s3_c%0d_stall", c), {31'd0, cpu_stall}, {31'd0, es});
      chk($sformatf("s3_c%0d_done", c), {31'd0, dma_done}, {31'd0, ed});
      if (eb) chk($sformatf("s3_c%0d_idx", c), {28'd0, dma_idx}, k);
      run = cpu_stall ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (eb) k++;
    end
    chk("s3_max_stall_ok", {31'd0, maxrun <= LIM}, 1);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 8; i++) chk($sformatf("s3_word%0d", i), mem[16+i], 32'h5000 + i);

    // Reset in the middle of a 6-beat write.
    for (int i = 0; i < 6; i++) pre[i] = mem[i];
    @(negedge clk);
    dma_req = 1; dma_we = 1; dma_addr = 32'h0; dma_len = 6;
    #1 chk("s6_accept_beat", {31'd0, dma_beat}, 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      dma_wdata = 32'h6000 + b;
      #1;
      chk($sformatf("s6_b%0d_beat", b), {31'd0, dma_beat}, 1);
      chk($sformatf("s6_b%0d_idx", b), {28'd0, dma_idx}, b);
    end
    @(negedge clk);
    clrn = 0; dma_req = 0; cpu_req = 1;
    #1;
    chk("s6_rst_we", {31'd0, ram_we}, 0);
    chk("s6_rst_beat", {31'd0, dma_beat}, 0);
    chk("s6_rst_stall", {31'd0, cpu_stall}, 1);
    chk("s6_rst_done", {31'd0, dma_done}, 0);
    @(negedge clk);
    clrn = 1; cpu_req = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("s6_post%0d_done", c), {31'd0, dma_done}, 0);
      chk($sformatf("s6_post%0d_we", c), {31'd0, ram_we}, 0);
      chk($sformatf("s6_post%0d_beat", c), {31'd0, dma_beat}, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) chk($sformatf("s6_written%0d", i), mem[i], 32'h6000 + i);
    for (int i = 3; i < 6; i++) chk($sformatf("s6_kept%0d", i), mem[i], pre[i]);

    // Random traffic against the reference model.
    m_mode = 0; m_wait = 0; m_run = 0; m_nb = 0; m_dir = 0; m_q.delete();
    for (int i = 0; i < 32; i++) m_mem[i] = mem[i];
    idle_inputs();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic g_cpu, g_beat, e_we, accept;
      logic [31:0] e_addr;
      logic [4:0]  w;
      @(negedge clk);
      cpu_req   = ($urandom % 4) != 0;
      cpu_we    = $urandom % 2;
      cpu_addr  = $urandom & 32'hFFFF_FFFC;
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
      if (m_mode == 2) dma_req = 0;
      else if (m_mode == 0 && !dma_req && ($urandom % 3) == 0) begin
        dma_req  = 1;
        dma_we   = $urandom % 2;
        dma_addr = $urandom;
        dma_len  = 4'($urandom_range(0, 8));
      end
      #1;
      g_cpu = 0; g_beat = 0; accept = 0;
      case (m_mode)
        0: begin
          g_cpu  = cpu_req;
          accept = dma_req && (!cpu_req || m_wait >= LIM);
        end
        1: if (cpu_req && m_run == LIM) g_cpu = 1; else g_beat = 1;
        default: g_cpu = cpu_req;
      endcase
      e_we   = g_cpu ? cpu_we : (g_beat ? m_dir : 1'b0);
      e_addr = g_cpu ? cpu_addr : (g_beat ? m_q[0] : 32'h0);
      chk("rnd_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !g_cpu});
      chk("rnd_beat", {31'd0, dma_beat}, {31'd0, g_beat});
      chk("rnd_we", {31'd0, ram_we}, {31'd0, e_we});
      chk("rnd_done", {31'd0, dma_done}, {31'd0, m_mode == 2});
      if (g_cpu || g_beat) chk("rnd_addr", ram_addr, e_addr);
      if (g_beat) chk("rnd_idx", {28'd0, dma_idx}, m_nb);
      if (e_we) chk("rnd_wdata", ram_wdata, g_cpu ? cpu_wdata : dma_wdata);
      if (g_cpu && !cpu_we) chk("rnd_cpu_rd", cpu_rdata, m_mem[cpu_addr[6:2]]);
      if (g_beat && !m_dir) chk("rnd_dma_rd", dma_rdata, m_mem[m_q[0][6:2]]);

      if (g_cpu && cpu_we) m_mem[cpu_addr[6:2]] = cpu_wdata;
      if (g_beat && m_dir) begin
        w = m_q[0][6:2];
        m_mem[w] = dma_wdata;
      end
      m_run = (cpu_req && !g_cpu) ? m_run + 1 : 0;
      case (m_mode)
        0: begin
          if (accept) begin
            m_dir = dma_we; m_nb = 0; m_wait = 0; m_q.delete();
            for (int b = 0; b < int'(dma_len); b++)
              m_q.push_back((dma_addr & 32'hFFFF_FF80) | ((((dma_addr >> 2) + b) % 32) << 2));
            m_mode = (dma_len == 0) ? 2 : 1;
          end else if (!dma_req) m_wait = 0;
          else m_wait++;
        end
        1: if (g_beat) begin
          void'(m_q.pop_front());
          m_nb++;
          if (m_q.size() == 0) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32-word data RAM between two requesters:
  - the pipeline MEM stage (CPU port);
  - a burst DMA/loader port that copies blocks in and out of the RAM.
- Sits between the MEM stage and the data RAM.
- The RAM read is combinational and the write is committed at posedge clk, so a granted access completes in one cycle.
- Arbitration is CPU-priority with a starvation bound in both directions.

Parameters:
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum DMA beats per burst.
- LEN_W, 4, width of dma_len; must hold MAX_BURST.
- STARVE_LIMIT, 4, maximum consecutive cycles one side may be held off while the other is served.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clrn  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  MEM stage wants the RAM this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; equals ram_rdata.
- cpu_stall  out  1  cpu_req and not granted this cycle; freezes the pipeline.
- dma_req  in  1  DMA burst request; held high until accepted.
- dma_we  in  1  burst direction: 1 = write RAM, 0 = read RAM.
- dma_addr  in  32  burst start byte address; must be word-aligned.
- dma_len  in  LEN_W  beats, 0..MAX_BURST.
- dma_wdata  in  DATA_W  write data for the current beat.
- dma_beat  out  1  DMA owns the RAM this cycle; the beat completes at the next posedge.
- dma_idx  out  LEN_W  index of the current beat.
- dma_rdata  out  DATA_W  read data for the current beat; equals ram_rdata.
- dma_done  out  1  one-cycle pulse after the last beat, or after acceptance of a zero-length burst.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM byte address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM combinational read data.

Behaviour:
- States: IDLE, BURST, DONE. Registers: state, base_addr, dir, len, idx, streak, dma_wait.
- Reset values: state = IDLE; all counters 0; dma_done = 0.
  - Combinational outputs are forced during reset: ram_we = 0, dma_beat = 0, cpu_stall = cpu_req.
- Grant:
  - CPU grant: ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata.
  - DMA beat: ram_addr = {base_addr[31:7], (base_addr[6:2] + idx)[4:0], 2'b00}, so the word index wraps 31 -> 0 inside the 128-byte window. ram_we = dir, ram_wdata = dma_wdata.
  - No grant: ram_we = 0.
- IDLE:
  - dma_req = 1 and (cpu_req = 0 or dma_wait == STARVE_LIMIT): accept the burst.
    - Latch dma_addr, dma_we, dma_len; set idx = 0, dma_wait = 0.
    - Next state is BURST, or DONE if dma_len == 0.
    - The acceptance cycle itself grants the CPU if cpu_req = 1; there is no DMA beat in this cycle.
  - Otherwise the CPU is granted when cpu_req = 1.
    - dma_wait increments while dma_req = 1 and cpu_req = 1; it clears when dma_req = 0.
- BURST:
  - Yield when cpu_req = 1 and streak == STARVE_LIMIT: CPU granted, no beat, streak = 0.
  - Otherwise a DMA beat occurs, with cpu_stall = cpu_req.
    - idx increments on each beat.
    - streak increments if cpu_req = 1, else clears to 0.
  - The beat with idx == len-1 moves the state to DONE.
- DONE:
  - dma_done = 1 for exactly one cycle; the CPU is granted if requesting.
  - dma_req is ignored in this cycle; the requester must drop it.
  - Next state is IDLE.
- Latency:
  - An uncontended CPU access has zero added latency.
  - A burst of N beats with no CPU traffic: accept, then N beats, then done = N+2 cycles.
- Worst-case CPU stall during a burst is STARVE_LIMIT consecutive cycles.
- dma_addr is word-aligned by requirement; bits [1:0] are ignored.
- Reset asserted mid-burst: the burst is aborted immediately, no further writes, no dma_done pulse; the requester must re-issue.
- cpu_req and cpu_we are sampled combinationally each cycle; the arbiter registers no CPU state.

Test Plan:
1. Reset, then cpu_req = 1, cpu_we = 1, cpu_addr = 0x50, cpu_wdata = 0xA3 -> cpu_stall = 0, ram_we = 1, ram_addr = 0x50. A read of 0x50 in the next cycle returns 0xA3.
2. dma_req = 1, dma_we = 0, dma_addr = 0x50, dma_len = 4, cpu idle -> beats at ram_addr 0x50/0x54/0x58/0x5C with dma_idx 0..3, then dma_done one cycle later; total 6 cycles.
3. cpu_req held at 1 throughout a 8-beat DMA write -> pattern of 4 beats (stall = 1), 1 CPU cycle (stall = 0), 4 beats. All 8 words written; the CPU is never stalled more than 4 consecutive cycles.
4. cpu_req = 1 continuously from IDLE with dma_req = 1 -> CPU served 4 cycles, then the burst is accepted in the 5th cycle.
5. dma_addr = 0x78, dma_len = 4 -> ram_addr sequence 0x78, 0x7C, 0x00, 0x04; dma_len = 0 -> no ram_we, dma_done pulses 1 cycle after acceptance.
6. clrn driven low after beat 2 of a 6-beat write -> ram_we = 0 at once, state IDLE, no dma_done; words 3..5 unchanged.
